sobel_frame_ctrl: RTL and testbench

- Frame-level controller that sequences the Sobel edge output stream into SDRAM writes.
- Arms on a start command and aligns to the vertical sync.
- Counts pixels and lines of the 12-bit edge/gray stream, selects the output mode from frame-synchronous config, flags SOF/EOF, and detects malformed frames.
- Sits between the absolute-value stage and the SDRAM write FIFO.

---
 rtl/sobel_pkg.sv | 34 +++
 rtl/sobel_frame_ctrl_pix_counter.sv | 42 ++++
 rtl/sobel_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, mode encodings and state type for the Sobel frame controller.
package sobel_pkg;

  localparam int PIX_W = 12;
  localparam logic [PIX_W-1:0] PIX_MAX = 12'd4095;

  localparam logic [1:0] MODE_GRAY = 2'd0;
  localparam logic [1:0] MODE_EDGE = 2'd1;
  localparam logic [1:0] MODE_BIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Output pixel selection; the reserved mode 3 behaves as edge mode.
  function automatic logic [PIX_W-1:0] sel_pix(
    input logic [1:0]       mode,
    input logic [PIX_W-1:0] thresh,
    input logic [PIX_W-1:0] gray_v,
    input logic [PIX_W-1:0] edge_v
  );
    logic [PIX_W-1:0] res;
    res = edge_v;
    if (mode == MODE_GRAY) begin
      res = gray_v;
    end else if (mode == MODE_BIN) begin
      res = (edge_v >= thresh) ? PIX_MAX : '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sobel_frame_ctrl_pix_counter.sv
// x/y pixel position counters with line wrap and a last-pixel-of-frame flag.
module sobel_pix_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 12
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             last
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  // Flags the final pixel of the frame at the current position.
  always_comb begin
    last = (x == X_LAST) && (y == Y_LAST);
  end

  // Advance position per accepted pixel; clear wins over advance.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller: arms on start, syncs to iVS, counts pixels/lines, selects
// the output pixel mode per frame, flags SOF/EOF and malformed frames.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 12
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic        iVS,
  input  logic        iCFG_WR,
  input  logic [1:0]  iCFG_MODE,
  input  logic [11:0] iCFG_THRESH,
  input  logic [11:0] iGRAY,
  input  logic [11:0] iEDGE,
  input  logic        iDVAL,
  output logic [11:0] oPIX,
  output logic        oDVAL,
  output logic        oSOF,
  output logic        oEOF,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY,
  output logic        oERR
);

  state_t           state;
  logic             stop_pending;
  logic [1:0]       shd_mode;
  logic [11:0]      shd_thresh;
  logic [1:0]       act_mode;
  logic [11:0]      act_thresh;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             last;
  logic             pix_fire;
  logic             eof_hit;
  logic             frame_start;
  logic             short_frame;
  logic             cnt_clr;

  // Decode per-cycle frame events; EOF takes precedence over a coincident iVS.
  always_comb begin
    pix_fire    = (state == RUN) && iDVAL;
    eof_hit     = pix_fire && last;
    frame_start = (state == ARM) && !iSTOP && iVS;
    short_frame = (state == RUN) && iVS && !eof_hit;
    cnt_clr     = frame_start || short_frame;
    oBUSY       = (state != IDLE);
  end

  sobel_pix_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .iCLK (iCLK),
    .iRST (iRST),
    .clr  (cnt_clr),
    .adv  (pix_fire),
    .x    (x),
    .y    (y),
    .last (last)
  );

  // Shadow config accepts writes in any state.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      shd_mode   <= MODE_EDGE;
      shd_thresh <= '0;
    end else if (iCFG_WR) begin
      shd_mode   <= iCFG_MODE;
      shd_thresh <= iCFG_THRESH;
    end
  end

  // Frame state machine, error/stop flags, frame count and active config.
  // Active config reads the pre-write shadow, so a same-cycle write lands next frame.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      oERR         <= 1'b0;
      oFRAME_CNT   <= '0;
      act_mode     <= MODE_EDGE;
      act_thresh   <= '0;
    end else begin
      if (frame_start || short_frame) begin
        act_mode   <= shd_mode;
        act_thresh <= shd_thresh;
      end
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            state        <= ARM;
            oERR         <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        ARM: begin
          if (iDVAL) oERR <= 1'b1;
          if (iSTOP) begin
            state <= IDLE;
          end else if (iVS) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (iSTOP) stop_pending <= 1'b1;
          if (short_frame) oERR <= 1'b1;
          if (eof_hit) begin
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
            state      <= (stop_pending || iSTOP) ? IDLE : ARM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered pixel path; oPIX holds when no pixel is emitted.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oPIX  <= '0;
      oDVAL <= 1'b0;
      oSOF  <= 1'b0;
      oEOF  <= 1'b0;
    end else begin
      oDVAL <= pix_fire;
      oSOF  <= pix_fire && (x == '0) && (y == '0);
      oEOF  <= eof_hit;
      if (pix_fire) oPIX <= sel_pix(act_mode, act_thresh, iGRAY, iEDGE);
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

  localparam int H = 4;
  localparam int V = 3;
  localparam int NPIX = H * V;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iSTART = 1'b0, iSTOP = 1'b0, iVS = 1'b0, iCFG_WR = 1'b0, iDVAL = 1'b0;
  logic [1:0]  iCFG_MODE = 2'd0;
  logic [11:0] iCFG_THRESH = '0, iGRAY = '0, iEDGE = '0;
  logic [11:0] oPIX;
  logic        oDVAL, oSOF, oEOF, oBUSY, oERR;
  logic [15:0] oFRAME_CNT;

  int checks = 0;
  int failures = 0;

  // Reference model state: phase 0=idle 1=armed 2=capturing, pixel index in frame.
  int          m_phase;
  int          m_n;
  int          m_fc;
  bit          m_err, m_stopreq;
  int          m_shd_mode, m_shd_th, m_act_mode, m_act_th;
  int          m_pix;
  bit          m_dval, m_sof, m_eof;

  sobel_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSTOP(iSTOP), .iVS(iVS),
    .iCFG_WR(iCFG_WR), .iCFG_MODE(iCFG_MODE), .iCFG_THRESH(iCFG_THRESH),
    .iGRAY(iGRAY), .iEDGE(iEDGE), .iDVAL(iDVAL), .oPIX(oPIX), .oDVAL(oDVAL),
    .oSOF(oSOF), .oEOF(oEOF), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_fc = 0; m_err = 0; m_stopreq = 0;
    m_shd_mode = 1; m_shd_th = 0; m_act_mode = 1; m_act_th = 0;
    m_pix = 0; m_dval = 0; m_sof = 0; m_eof = 0;
  endtask

  function automatic int ref_pix(int mode, int th, int g, int e);
    if (mode == 0) return g;
    if (mode == 2) return (e >= th) ? 4095 : 0;
    return e;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".dval"}, int'(oDVAL), int'(m_dval));
    chk({ctx, ".pix"}, int'(oPIX), m_pix);
    chk({ctx, ".sof"}, int'(oSOF), int'(m_sof));
    chk({ctx, ".eof"}, int'(oEOF), int'(m_eof));
    chk({ctx, ".fcnt"}, int'(oFRAME_CNT), m_fc % 65536);
    chk({ctx, ".err"}, int'(oERR), int'(m_err));
    chk({ctx, ".busy"}, int'(oBUSY), int'(m_phase != 0));
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic cyc(input bit st, input bit sp, input bit vs, input bit wr,
                     input int md, input int th, input bit dv, input int ev,
                     input string ctx);
    int g;
    bit last_px;
    g = int'($urandom_range(0, 4095));
    iSTART = st; iSTOP = sp; iVS = vs; iCFG_WR = wr;
    iCFG_MODE = 2'(md); iCFG_THRESH = 12'(th);
    iDVAL = dv; iGRAY = 12'(g); iEDGE = 12'(ev);
    m_dval = 0; m_sof = 0; m_eof = 0;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_err = 0; m_stopreq = 0; end
      1: begin
        if (dv) m_err = 1;
        if (sp) m_phase = 0;
        else if (vs) begin
          m_phase = 2; m_n = 0; m_act_mode = m_shd_mode; m_act_th = m_shd_th;
        end
      end
      default: begin
        last_px = dv && (m_n == NPIX - 1);
        if (dv) begin
          m_dval = 1;
          m_pix = ref_pix(m_act_mode, m_act_th, g, ev);
          m_sof = (m_n == 0);
          m_eof = last_px;
          m_n = last_px ? 0 : m_n + 1;
        end
        if (last_px) begin
          m_fc++;
          m_phase = (m_stopreq || sp) ? 0 : 1;
        end else if (vs) begin
          m_err = 1; m_n = 0; m_act_mode = m_shd_mode; m_act_th = m_shd_th;
        end
        if (sp) m_stopreq = 1;
      end
    endcase
    if (wr) begin m_shd_mode = md; m_shd_th = th; end
    @(posedge iCLK);
    #1;
    check_all(ctx);
  endtask

  task automatic idle_cyc(input string ctx);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ctx);
  endtask

  task automatic pix(input int ev, input string ctx);
    cyc(0, 0, 0, 0, 0, 0, 1, ev, ctx);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge iCLK);
    #1;
    check_all("reset");
    iRST = 1'b1;
    idle_cyc("post_reset");

    // Basic frame in edge mode
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs1");
    for (int i = 0; i < NPIX; i++) pix(i, "f1");
    idle_cyc("f1_after");

    // Mid-frame config write applies to the next frame only
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs2");
    for (int i = 0; i < 5; i++) pix(i, "f2a");
    cyc(0, 0, 0, 1, 2, 6, 0, 0, "cfg_bin");
    for (int i = 5; i < NPIX; i++) pix(i, "f2b");
    // Same-cycle write with iVS: this frame stays binary, next frame gray
    cyc(0, 0, 1, 1, 0, 0, 0, 0, "vs3_wr");
    for (int i = 0; i < NPIX; i++) pix(i, "f3_bin");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs4");
    for (int i = 0; i < NPIX; i++) pix(int'($urandom_range(0, 4095)), "f4_gray");

    // Short frame
    cyc(0, 0, 0, 1, 1, 0, 0, 0, "cfg_edge");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs5");
    for (int i = 0; i < 7; i++) pix(i, "short");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs_short");
    for (int i = 0; i < NPIX; i++) pix(int'($urandom_range(0, 4095)), "after_short");

    // Stop mid-frame: frame completes, then idle ignores traffic
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs6");
    for (int i = 0; i < 5; i++) pix(i, "stop_a");
    cyc(0, 1, 0, 0, 0, 0, 1, 5, "stop_px");
    for (int i = 6; i < NPIX; i++) pix(i, "stop_b");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "idle_vs");
    for (int i = 0; i < 3; i++) pix(i, "idle_px");

    // Long frame: pixel while armed
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start2");
    pix(99, "long_px");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "stop_arm");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_clr");

    // Randomised traffic against the model
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom % 8) == 0, ($urandom % 24) == 0, ($urandom % 12) == 0,
          ($urandom % 8) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
          ($urandom % 4) != 0, int'($urandom_range(0, 4095)), "rand");
    end

    // Reset in the middle of a frame
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "pre_stop");
    for (int i = 0; i < NPIX + 2; i++) idle_cyc("drain");
    cyc(0, 1, 0, 0, 0, 0, 1, 0, "drain2");
    for (int i = 0; i < NPIX + 2; i++) pix(i, "drain3");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start3");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs7");
    for (int i = 0; i < 6; i++) pix(i + 100, "pre_rst");
    #2;
    iRST = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    idle_cyc("rst_idle");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start4");
    cyc(0, 0, 1, 0, 0, 0, 0, 0, "vs8");
    for (int i = 0; i < NPIX; i++) pix(i, "f_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
